irq_injector: RTL and testbench
===============================

# irq_injector

Memory-mapped interrupt source for the P7 CPU, modelled as a bus peripheral. Software loads a queue of trigger PCs and enables the block. When the CPU's `macroscopic_pc` (word-aligned) matches the queue head, the block raises `interrupt` and holds it until the handler stores to the ACK register. It sits on the data bus beside DM and makes the test harness's inline interrupt logic reusable in RTL.

## Interface
- `BASE`, 32'h0000_7F20, base byte address of the four-word register window
- `DEPTH`, 4, trigger FIFO entries (power of two, ≥2)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset), one clock domain
- `macroscopic_pc`  in  32  CPU architectural PC; bits [1:0] ignored
- `m_data_addr`  in  32  bus byte address
- `m_data_wdata`  in  32  bus write data
- `m_data_byteen`  in  4  byte write enables; nonzero = write
- `m_data_rdata`  out  32  combinational read data for the window; 0 outside it
- `interrupt`  out  1  level interrupt to CPU

## Operation
- Register map (word offsets from BASE):
  - +0 ACK: any write with a nonzero byteen clears a pending interrupt. Reads return 0.
  - +4 TRIG: a write with byteen=4'b1111 pushes wdata&~3 into the FIFO. Reads return the head, or 0 if empty.
  - +8 STATUS (read-only): [7:0] irq_count, [8] pending, [9] empty, [10] full, [11] overflow, [15:12] fill count, others 0.
  - +C CTRL: a write with byteen=4'b1111 sets bit0 enable. Writing bit1=1 flushes the FIFO and clears overflow; bit1 reads back 0.
- Partial-byteen writes to TRIG and CTRL are ignored.
- FSM has three states:
  - IDLE: go to ARMED when enable=1 and the FIFO is non-empty.
  - ARMED: compare `macroscopic_pc&~3` to the head every cycle. On a match: pop the head, set `interrupt`, increment irq_count (8-bit, wraps 255→0), go to PENDING. If enable=0 or the FIFO is empty, go to IDLE.
  - PENDING: no comparison. An ACK write clears `interrupt`, then go to IDLE.
- Boundary rules:
  - Push while full: data dropped, overflow set (sticky).
  - Push and pop in the same cycle: both take effect; fill count unchanged.
  - Flush in PENDING: FIFO emptied, `interrupt` held until ACK.
  - ACK outside PENDING: no effect.
  - Disable in PENDING: `interrupt` held until ACK.
  - Flush and push in the same write are impossible (different registers). A CTRL write with flush=1 and enable=1 leaves the FIFO empty and enable=1.
  - Head/tail pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous deassert at the clock edge): `interrupt`=0, state IDLE, FIFO empty, enable=0, overflow=0, irq_count=0. `m_data_rdata` follows the cleared state immediately.
- Register writes take effect at the rising edge of the write cycle. The new value is readable in the next cycle.
- Match latency: a match sampled at edge N drives `interrupt`=1 after edge N. Pop and irq_count update happen at the same edge.
- ACK latency: an ACK write sampled at edge N drives `interrupt`=0 after edge N. The earliest following match is sampled at edge N+2: N+1 moves IDLE→ARMED, N+2 compares.
- Enable written at edge N: IDLE→ARMED at N+1; first compare at N+2.
- `m_data_rdata` is purely combinational from `m_data_addr` and current state.

## Structure
- Shared package `irq_injector_pkg`:
  - register offsets (ACK=0, TRIG=4, STATUS=8, CTRL=12)
  - STATUS bit positions
  - FSM state enum {IDLE, ARMED, PENDING}
- One sub-module, `trig_fifo` (parameter DEPTH, 32-bit data). It provides push, pop, flush, head, count, full and empty, with simultaneous push/pop support.
- The top level holds the FSM, address decode, read mux and counters.

## Test plan
- Reset with `reset`=0 mid-PENDING → `interrupt`=0 immediately; STATUS reads 0x0200 (empty only).
- Push 0x3010, 0x3038, 0x3054, set enable, step PC 0x3000→0x3010 → `interrupt`=1 one edge after PC=0x3010 is sampled. STATUS shows pending=1, count=2, irq_count=1.
- In PENDING, drive PC=0x3038 (the head) → no pop and count stays 2. ACK write (byteen=4'b0001 at BASE) → `interrupt`=0 next edge; PC=0x3038 then fires at ACK+2 edges.
- Push five entries with DEPTH=4 → full=1, overflow=1, fill count=4; TRIG read returns the first entry. Flush → empty=1, overflow=0.
- Push while the head matches in the same cycle → fill count unchanged and the new entry lands at the tail. PC 0x3012 matches head 0x3010 (low bits masked).
- 256 match/ACK cycles → irq_count wraps to 0. Partial-byteen TRIG write (4'b0011) → FIFO unchanged.

Source files
------------

// File: rtl/irq_injector_pkg.sv
// Shared definitions for the PC-triggered interrupt injector: register map,
// STATUS bit layout and controller states.
package irq_injector_pkg;

  localparam logic [3:0] OFF_ACK    = 4'h0;
  localparam logic [3:0] OFF_TRIG   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int STAT_PENDING  = 8;
  localparam int STAT_EMPTY    = 9;
  localparam int STAT_FULL     = 10;
  localparam int STAT_OVERFLOW = 11;
  localparam int STAT_FILL_LSB = 12;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_PENDING = 2'd2
  } state_e;

  // Maps a byte address onto its word offset inside the 16-byte window.
  function automatic logic [3:0] word_off(input logic [31:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_injector_trig_fifo.sv
// Trigger-PC FIFO: circular buffer with simultaneous push/pop and flush.
// Pushes into a full FIFO are dropped; pops from an empty FIFO are ignored.
module trig_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/irq_injector.sv
// Memory-mapped interrupt source: raises a level interrupt when the CPU PC
// reaches the head of a software-loaded trigger queue; cleared by an ACK store.
//
// state     | meaning
// S_IDLE    | waiting for enable and a non-empty trigger queue
// S_ARMED   | comparing the word-aligned PC against the queue head each cycle
// S_PENDING | interrupt asserted, waiting for an ACK write
module irq_injector
  import irq_injector_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0000_7F20,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        interrupt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e      r_state;
  logic        r_irq;
  logic [7:0]  r_irq_count;
  logic        r_enable;
  logic        r_overflow;

  logic        w_in_win;
  logic [3:0]  w_off;
  logic        w_full_word;
  logic        w_ack_wr;
  logic        w_trig_wr;
  logic        w_ctrl_wr;
  logic        w_flush;
  logic        w_match;
  logic [31:0] w_head;
  logic [CW-1:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_unused_addr;

  assign w_in_win      = (m_data_addr[31:4] == BASE[31:4]);
  assign w_off         = word_off(m_data_addr);
  assign w_full_word   = (m_data_byteen == 4'b1111);
  assign w_ack_wr      = w_in_win && (w_off == OFF_ACK)  && (m_data_byteen != 4'b0000);
  assign w_trig_wr     = w_in_win && (w_off == OFF_TRIG) && w_full_word;
  assign w_ctrl_wr     = w_in_win && (w_off == OFF_CTRL) && w_full_word;
  assign w_flush       = w_ctrl_wr && m_data_wdata[CTRL_FLUSH_BIT];
  assign w_unused_addr = ^m_data_addr[1:0];

  assign w_match = (r_state == S_ARMED) && r_enable && !w_empty &&
                   ((macroscopic_pc & ~32'h3) == w_head);

  trig_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_trig_wr),
    .i_pop   (w_match),
    .i_flush (w_flush),
    .i_wdata (m_data_wdata & ~32'h3),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_irq       <= 1'b0;
      r_irq_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_enable && !w_empty) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (w_match) begin
            r_state     <= S_PENDING;
            r_irq       <= 1'b1;
            r_irq_count <= r_irq_count + 8'd1;
          end else if (!r_enable || w_empty) begin
            r_state <= S_IDLE;
          end
        end
        S_PENDING: begin
          if (w_ack_wr) begin
            r_irq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_enable <= m_data_wdata[CTRL_EN_BIT];
      if (w_flush)
        r_overflow <= 1'b0;
      else if (w_trig_wr && w_full)
        r_overflow <= 1'b1;
    end
  end

  always_comb begin
    m_data_rdata = 32'd0;
    if (w_in_win) begin
      case (w_off)
        OFF_TRIG:   m_data_rdata = w_empty ? 32'd0 : w_head;
        OFF_STATUS: begin
          m_data_rdata[7:0]           = r_irq_count;
          m_data_rdata[STAT_PENDING]  = (r_state == S_PENDING);
          m_data_rdata[STAT_EMPTY]    = w_empty;
          m_data_rdata[STAT_FULL]     = w_full;
          m_data_rdata[STAT_OVERFLOW] = r_overflow;
          m_data_rdata[STAT_FILL_LSB +: 4] = 4'(w_count);
        end
        OFF_CTRL:   m_data_rdata[CTRL_EN_BIT] = r_enable;
        default:    m_data_rdata = 32'd0;
      endcase
    end
  end

  assign interrupt = r_irq;

endmodule

// File: tb/tb_irq_injector.sv
// Self-checking bench for irq_injector: directed scenarios plus random bus/PC
// traffic against a queue-based behavioural model.
module tb_irq_injector;

  localparam logic [31:0] BASE  = 32'h0000_7F20;
  localparam int          DEPTH = 4;
  localparam logic [31:0] A_ACK  = BASE;
  localparam logic [31:0] A_TRIG = BASE + 32'd4;
  localparam logic [31:0] A_STAT = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] macroscopic_pc = '0;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic [31:0] m_data_rdata;
  logic        interrupt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  logic        m_en, m_ovf, m_pend, m_armed;
  logic [7:0]  m_cnt;

  irq_injector #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .macroscopic_pc (macroscopic_pc),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_data_rdata   (m_data_rdata),
    .interrupt      (interrupt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if ((a >> 4) == (BASE >> 4)) begin
      case (a[3:2])
        2'd1: r = (q.size() > 0) ? q[0] : 32'd0;
        2'd2: r = {16'd0, 4'(q.size()), m_ovf, (q.size() == DEPTH), (q.size() == 0), m_pend, m_cnt};
        2'd3: r = {31'd0, m_en};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_reg(input logic [31:0] a, input logic [31:0] reg_addr);
    return (a & ~32'h3) == reg_addr;
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 0; m_ovf = 0; m_pend = 0; m_armed = 0; m_cnt = 8'd0;
  endtask

  // One rising edge of behaviour, computed from the pre-edge inputs and state.
  task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] pc);
    logic was_full, hit;
    was_full = (q.size() == DEPTH);
    hit = m_armed && m_en && (q.size() > 0) && ((pc & ~32'h3) == q[0]);
    if (hit) begin
      void'(q.pop_front());
      m_pend = 1; m_armed = 0; m_cnt = m_cnt + 8'd1;
    end else if (m_pend) begin
      if (is_reg(a, A_ACK) && be != 4'd0) m_pend = 0;
    end else if (m_armed) begin
      if (!m_en || q.size() == 0) m_armed = 0;
    end else if (m_en && q.size() > 0) begin
      m_armed = 1;
    end
    if (is_reg(a, A_TRIG) && be == 4'hF) begin
      if (was_full) m_ovf = 1;
      else q.push_back(wd & ~32'h3);
    end
    if (is_reg(a, A_CTRL) && be == 4'hF) begin
      m_en = wd[0];
      if (wd[1]) begin
        q.delete();
        m_ovf = 0;
      end
    end
  endtask

  task automatic tick(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] pc);
    @(negedge clk);
    m_data_addr = a; m_data_wdata = wd; m_data_byteen = be; macroscopic_pc = pc;
    #1 check_val("rdata", m_data_rdata, model_read(a));
    @(posedge clk);
    model_step(a, wd, be, pc);
    #1 check_val("irq", {31'd0, interrupt}, {31'd0, m_pend});
  endtask

  // Combinational read right after an edge; no clock edge is consumed.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    m_data_byteen = 4'd0;
    m_data_addr = a;
    #1 d = m_data_rdata;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    m_data_byteen = 4'd0;
    m_data_addr = A_STAT;
    #1 check_val("rst_irq", {31'd0, interrupt}, 32'd0);
    check_val("rst_status", m_data_rdata, 32'h0000_0200);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] pc, a, wd;
    logic [3:0]  be;
    logic [31:0] rd_addrs [7];
    rd_addrs = '{A_ACK, A_TRIG, A_STAT, A_CTRL, BASE + 32'd16, BASE - 32'd4, 32'd0};
    model_reset();
    repeat (2) @(negedge clk);
    reset_dut();

    // basic trigger sequence
    tick(A_TRIG, 32'h3010, 4'hF, 32'h0);
    tick(A_TRIG, 32'h3038, 4'hF, 32'h0);
    tick(A_TRIG, 32'h3054, 4'hF, 32'h0);
    tick(A_CTRL, 32'h1, 4'hF, 32'h3000);
    for (int p = 32'h3004; p <= 32'h3010; p += 4) tick(A_STAT, 0, 4'h0, p);
    check_val("fire", {31'd0, interrupt}, 32'd1);
    peek(A_STAT, d);
    check_val("status_fire", d, 32'h0000_2101);
    tick(A_STAT, 0, 4'h0, 32'h3038);
    tick(A_STAT, 0, 4'h0, 32'h3038);
    peek(A_STAT, d);
    check_val("no_cmp_pending", d, 32'h0000_2101);
    tick(A_ACK, 0, 4'b0001, 32'h3038);
    check_val("ack_clear", {31'd0, interrupt}, 32'd0);
    tick(A_STAT, 0, 4'h0, 32'h3038);
    check_val("ack_plus1", {31'd0, interrupt}, 32'd0);
    tick(A_STAT, 0, 4'h0, 32'h3038);
    check_val("ack_plus2", {31'd0, interrupt}, 32'd1);
    reset_dut();

    // overflow and flush
    for (int i = 0; i < 5; i++) tick(A_TRIG, 32'h3100 + 4 * i, 4'hF, 32'h0);
    peek(A_STAT, d);
    check_val("status_ovf", d, 32'h0000_4C00);
    peek(A_TRIG, d);
    check_val("head_ovf", d, 32'h0000_3100);
    tick(A_CTRL, 32'h2, 4'hF, 32'h0);
    peek(A_STAT, d);
    check_val("status_flush", d, 32'h0000_0200);
    tick(A_TRIG, 32'h3300, 4'b0011, 32'h0);
    peek(A_STAT, d);
    check_val("partial_trig", d, 32'h0000_0200);

    // push and pop in the same cycle, low PC bits masked
    tick(A_TRIG, 32'h3010, 4'hF, 32'h0);
    tick(A_TRIG, 32'h3020, 4'hF, 32'h0);
    tick(A_CTRL, 32'h1, 4'hF, 32'h0);
    tick(A_STAT, 0, 4'h0, 32'h0);
    tick(A_TRIG, 32'h3030, 4'hF, 32'h3012);
    peek(A_STAT, d);
    check_val("pushpop_status", d, 32'h0000_2101);
    peek(A_TRIG, d);
    check_val("pushpop_head", d, 32'h0000_3020);
    tick(A_ACK, 0, 4'hF, 32'h0);
    tick(A_STAT, 0, 4'h0, 32'h0);
    tick(A_STAT, 0, 4'h0, 32'h3020);
    peek(A_TRIG, d);
    check_val("tail_entry", d, 32'h0000_3030);
    reset_dut();

    // irq_count wrap after 256 interrupts
    tick(A_CTRL, 32'h1, 4'hF, 32'h0);
    for (int n = 0; n < 256; n++) begin
      tick(A_TRIG, 32'h3010, 4'hF, 32'h0);
      for (int k = 0; k < 8 && !interrupt; k++) tick(A_STAT, 0, 4'h0, 32'h3010);
      check_val("wrap_fire", {31'd0, interrupt}, 32'd1);
      tick(A_ACK, 0, 4'hF, 32'h0);
    end
    peek(A_STAT, d);
    check_val("wrap_cnt", {24'd0, d[7:0]}, 32'd0);
    reset_dut();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      if (q.size() > 0 && $urandom_range(0, 1) == 1) pc = q[0] | 32'($urandom_range(0, 3));
      else pc = 32'h3000 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      wd = 32'h3000 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      be = 4'hF;
      case ($urandom_range(0, 9))
        0, 1, 2: a = A_TRIG;
        3: begin a = A_TRIG; be = 4'($urandom_range(1, 14)); end
        4: begin
             a = A_CTRL;
             wd = {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
           end
        5: begin a = A_ACK; be = 4'($urandom_range(1, 15)); end
        6: begin a = A_CTRL; be = 4'($urandom_range(1, 14)); wd = 32'h0000_0002; end
        default: begin a = rd_addrs[$urandom_range(0, 6)]; be = 4'h0; end
      endcase
      tick(a, wd, be, pc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
